// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences PC write/redirect and pipeline flushes for branches, FENCE drains and ECALL/EBREAK halts.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [1:0]  ex_sys_kind,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        mem_stall,
  input  logic        resume,
  input  logic [31:0] resume_pc,
  output logic        pc_we,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        halted,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01, DRAIN = 2'b10, HALT = 2'b11} st_t;
  st_t         cur, nxt;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] saved_pc, saved_pc_n;
  logic [1:0]  saved_kind, saved_kind_n;
  logic        we, rd, fl;
  logic [31:0] rpc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= RUN;
      cnt        <= '0;
      saved_pc   <= '0;
      saved_kind <= '0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_n;
      saved_pc   <= saved_pc_n;
      saved_kind <= saved_kind_n;
    end
  end
  // a stalled cycle keeps every default: no writes, no flush, state held
  always_comb begin
    nxt          = cur;
    cnt_n        = cnt;
    saved_pc_n   = saved_pc;
    saved_kind_n = saved_kind;
    we           = 1'b0;
    rd           = 1'b0;
    rpc          = '0;
    fl           = 1'b0;
    if (!mem_stall) begin
      case (cur)
        RUN: begin
          we = 1'b1;
          if (ex_valid && |ex_sys_kind) begin
            we           = 1'b0;
            fl           = 1'b1;
            saved_pc_n   = ex_pc;
            saved_kind_n = ex_sys_kind;
            cnt_n        = 3'(DRAIN_CYCLES - 1);
            nxt          = DRAIN;
          end else if (ex_valid && ex_branch) begin
            rd  = 1'b1;
            rpc = ex_target;
            fl  = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              cnt_n = 3'(FLUSH_CYCLES - 1);
              nxt   = FLUSH;
            end
          end
        end
        FLUSH: begin
          we    = 1'b1;
          fl    = 1'b1;
          nxt   = cnt == 3'd0 ? RUN : FLUSH;
          cnt_n = cnt == 3'd0 ? cnt : cnt - 3'd1;
        end
        DRAIN: begin
          fl = 1'b1;
          if (cnt != 3'd0) cnt_n = cnt - 3'd1;
          else if (saved_kind == 2'b10) begin
            we  = 1'b1;
            rd  = 1'b1;
            rpc = saved_pc + 32'd4;
            nxt = RUN;
          end else nxt = HALT;
        end
        HALT: begin
          fl = 1'b1;
          if (resume) begin
            we  = 1'b1;
            rd  = 1'b1;
            rpc = resume_pc;
            nxt = RUN;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end
  assign pc_we       = rst & we;
  assign pc_redirect = rst & rd;
  assign redirect_pc = rst ? rpc : '0;
  assign flush_ifid  = rst & fl;
  assign flush_idex  = rst & fl;
  assign halted      = cur == HALT;
  assign state       = cur;
  a_redir_we: assert property (@(posedge clk) pc_redirect |-> pc_we);
  a_halt_st:  assert property (@(posedge clk) halted |-> state == HALT);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: vector table and hand-written sequences, expected outputs queued as scoreboard entries.
module tb_pc_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_branch, mem_stall, resume;
  logic [1:0]  ex_sys_kind;
  logic [31:0] ex_pc, ex_target, resume_pc;
  logic        pc_we, pc_redirect, flush_ifid, flush_idex, halted;
  logic [31:0] redirect_pc;
  logic [1:0]  state;
  int          total = 0, passed = 0;

  typedef struct {
    logic        v, b;
    logic [1:0]  k;
    logic [31:0] pc, tgt;
    logic        st, rs;
    logic [31:0] rpc_in;
    logic        we, rd;
    logic [31:0] rpc;
    logic        fl, h;
    logic [1:0]  s;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  pc_redirect_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_sys_kind(ex_sys_kind),
    .ex_pc(ex_pc), .ex_target(ex_target), .mem_stall(mem_stall), .resume(resume), .resume_pc(resume_pc),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic b, logic [1:0] k, logic [31:0] pc, logic [31:0] tgt,
                              logic st, logic rs, logic [31:0] rpc_in, logic we, logic rd,
                              logic [31:0] rpc, logic fl, logic h, logic [1:0] s);
    vec_t x;
    x.v = v; x.b = b; x.k = k; x.pc = pc; x.tgt = tgt; x.st = st; x.rs = rs; x.rpc_in = rpc_in;
    x.we = we; x.rd = rd; x.rpc = rpc; x.fl = fl; x.h = h; x.s = s;
    return x;
  endfunction

  function automatic vec_t idle(logic st, logic we, logic rd, logic [31:0] rpc, logic fl, logic h, logic [1:0] s);
    return mk(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, st, 1'b0, 32'h0, we, rd, rpc, fl, h, s);
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%h exp=%h", n, a, e);
  endtask

  task automatic apply(vec_t x, string tag);
    vec_t e;
    @(posedge clk);
    #1;
    ex_valid = x.v; ex_branch = x.b; ex_sys_kind = x.k; ex_pc = x.pc; ex_target = x.tgt;
    mem_stall = x.st; resume = x.rs; resume_pc = x.rpc_in;
    exp_q.push_back(x);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".pc_we"}, 32'(pc_we), 32'(e.we));
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(e.rd));
    chk({tag, ".redirect_pc"}, redirect_pc, e.rpc);
    chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e.fl));
    chk({tag, ".flush_idex"}, 32'(flush_idex), 32'(e.fl));
    chk({tag, ".halted"}, 32'(halted), 32'(e.h));
    chk({tag, ".state"}, 32'(state), 32'(e.s));
  endtask

  initial begin
    rst = 1'b0;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_sys_kind = 2'b00; ex_pc = 32'h10; ex_target = 32'h100;
    mem_stall = 1'b0; resume = 1'b1; resume_pc = 32'h200;
    #7;
    chk("rst.pc_we", 32'(pc_we), 0);
    chk("rst.pc_redirect", 32'(pc_redirect), 0);
    chk("rst.redirect_pc", redirect_pc, 0);
    chk("rst.flush", 32'({flush_ifid, flush_idex}), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.state", 32'(state), 0);
    #5 rst = 1'b1;
    ex_valid = 1'b0; ex_branch = 1'b0; resume = 1'b0;

    tbl.push_back(idle(0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 1, 2'b00, 32'h10, 32'h100, 0, 0, 0, 1, 1, 32'h100, 1, 0, 2'd0));
    tbl.push_back(idle(0, 1, 0, 0, 1, 0, 2'd1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h20, 32'h700, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 0, 2'b10, 32'h40, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    tbl.push_back(idle(0, 0, 0, 0, 1, 0, 2'd2));
    tbl.push_back(idle(0, 1, 1, 32'h44, 1, 0, 2'd2));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 1, 2'b10, 32'h60, 32'h500, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    tbl.push_back(idle(0, 0, 0, 0, 1, 0, 2'd2));
    tbl.push_back(idle(0, 1, 1, 32'h64, 1, 0, 2'd2));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 1, 2'b00, 32'h70, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 1, 2'b00, 32'h70, 32'h300, 0, 0, 0, 1, 1, 32'h300, 1, 0, 2'd0));
    tbl.push_back(mk(1, 1, 2'b00, 32'h74, 32'h900, 0, 0, 0, 1, 0, 0, 1, 0, 2'd1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(1, 0, 2'b11, 32'h80, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 1, 32'hdead, 0, 0, 0, 1, 0, 2'd2));
    tbl.push_back(idle(0, 0, 0, 0, 1, 0, 2'd2));
    tbl.push_back(idle(0, 0, 0, 0, 1, 1, 2'd3));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    for (int i = 0; i < 20; i++)
      apply(mk(1, 1, 2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0, 0, 0, 0, 0, 1, 1, 2'd3),
            $sformatf("halt%0d", i));
    apply(mk(0, 0, 2'b00, 0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 1, 2'd3), "res_stall");
    apply(mk(0, 0, 2'b00, 0, 0, 0, 1, 32'h200, 1, 1, 32'h200, 1, 1, 2'd3), "resume");
    apply(idle(0, 1, 0, 0, 0, 0, 2'd0), "post_resume");

    apply(mk(1, 0, 2'b10, 32'h1000, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), "dstall_in");
    for (int i = 0; i < 3; i++)
      apply(mk(1, 1, 2'b01, 32'h5000, 32'h6000, 1, 1, 32'h7000, 0, 0, 0, 0, 0, 2'd2), $sformatf("dstall%0d", i));
    apply(idle(0, 0, 0, 0, 1, 0, 2'd2), "dstall_c1");
    apply(idle(0, 1, 1, 32'h1004, 1, 0, 2'd2), "dstall_c0");
    apply(idle(0, 1, 0, 0, 0, 0, 2'd0), "dstall_run");

    apply(mk(1, 0, 2'b10, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), "wrap_in");
    apply(idle(0, 0, 0, 0, 1, 0, 2'd2), "wrap_c1");
    apply(idle(0, 1, 1, 32'h0, 1, 0, 2'd2), "wrap_c0");

    apply(mk(1, 0, 2'b01, 32'h90, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), "ar_in");
    apply(idle(0, 0, 0, 0, 1, 0, 2'd2), "ar_c1");
    apply(idle(0, 0, 0, 0, 1, 0, 2'd2), "ar_c0");
    apply(idle(0, 0, 0, 0, 1, 1, 2'd3), "ar_halt");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst.halted", 32'(halted), 0);
    chk("arst.state", 32'(state), 0);
    chk("arst.pc_we", 32'(pc_we), 0);
    chk("arst.flush", 32'({flush_ifid, flush_idex}), 0);
    @(negedge clk);
    rst = 1'b1;
    apply(idle(0, 1, 0, 0, 0, 0, 2'd0), "arst_run");
    apply(mk(1, 1, 2'b00, 32'h10, 32'h2468, 0, 0, 0, 1, 1, 32'h2468, 1, 0, 2'd0), "arst_br");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
